regbank_param: RTL and testbench
================================

# regbank_param

Parametrised successor to the CPU register bank. It provides a configurable data width, depth and number of combinational read ports, an optional write-to-read bypass for the pipelined core, and a debug read port for the VGA and display taps. Storage has no per-entry reset, so it can infer RAM. Instead, an initialisation sequencer clears the bank one entry per cycle after reset or on a software clear request, and loads the stack-pointer entry with its initial value. The block sits in the CPU decode stage, replacing the fixed 32x32 two-port bank.

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; depth NREG = 2^ADDR_W
- NRD, 2, number of read ports (1..4)
- SP_IDX, 2, index of the stack-pointer entry
- SP_INIT, 32'h0000_3FFC, value loaded into SP_IDX during initialisation (truncated/zero-extended to DATA_W)
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports
- iCLK  in  1  clock; all state updates on posedge
- iRST  in  1  asynchronous, active-high reset
- iClear  in  1  synchronous request to re-run initialisation
- iRegWrite  in  1  write enable
- iWriteRegister  in  ADDR_W  write address
- iWriteData  in  DATA_W  write data
- iReadRegister  in  NRD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- oReadData  out  NRD*DATA_W  read data; port p uses bits [p*DATA_W +: DATA_W]
- iDbgSelect  in  ADDR_W  debug/VGA read address
- oDbgData  out  DATA_W  debug read data (never bypassed)
- oReady  out  1  bank initialised and accepting writes

## Operation
- States: INIT and READY. A counter cnt of ADDR_W+1 bits tracks progress.
- iRST asserted: state=INIT, cnt=0, oReady=0, asynchronously.
- INIT, each posedge: write mem[cnt] <= (cnt==SP_IDX ? SP_INIT : 0) and increment cnt. After the write to entry NREG-1, state becomes READY and oReady=1.
- INIT lasts exactly NREG cycles.
- READY, posedge with iRegWrite=1 and iWriteRegister!=0: mem[iWriteRegister] <= iWriteData.
- Writes to entry 0 are always discarded. Entry 0 always reads 0.
- iClear=1 in READY: the next state is INIT with cnt=0. A write presented in the same cycle is dropped, so clear wins.
- iClear=1 in INIT: cnt restarts at 0 and the full sweep repeats.
- Writes presented while oReady=0 are ignored. The core must stall on !oReady.
- Read port p, combinational:
  - oReady=0: returns 0.
  - Address 0: returns 0.
  - BYPASS=1, iRegWrite=1, oReady=1, iClear=0 and the address equals iWriteRegister (non-zero): returns iWriteData.
  - Otherwise: returns mem[addr].
- oDbgData = mem[iDbgSelect] combinationally, with no bypass and no gating by oReady. During INIT it may show partially cleared contents.
- Out-of-range parameters are a configuration error and are not checked in RTL:
  - SP_IDX = 0 or SP_IDX >= NREG
  - NRD outside 1..4

## Timing
- Reset values: oReady=0, state=INIT, cnt=0. oReadData is all zero while oReady=0. Memory contents are undefined until INIT completes.
- Release of iRST followed by edges E1..E_NREG: entry k is written at E(k+1). oReady rises after E_NREG. For the defaults this is 32 edges.
- iRST asserted mid-INIT or mid-READY: the block returns to INIT/cnt=0 immediately. Any write in flight is lost.
- Write latency: 1 cycle to storage. With BYPASS=0, reading the written address returns the new value from the cycle after the write edge. With BYPASS=1, it returns the new value in the same cycle.
- Multiple read ports may address the same or different entries with no conflict. There is a single write port.
- iClear is level-sampled at each posedge. Holding it high keeps the bank in INIT with cnt pinned at 0/1.

## Test plan
- Reset sweep: pulse iRST, then count edges. oReady=0 for exactly 32 cycles and rises after edge 32. Then read port 0 @2 = 32'h0000_3FFC and @5 = 0, and oDbgData @31 = 0.
- Write/read with BYPASS=1: write 32'hDEADBEEF to x7. In the same cycle port 1 @7 reads DEADBEEF. The next cycle, with no write, both ports @7 read DEADBEEF.
- x0 protection: write 32'h12345678 to x0. The port reads 0 in the same cycle and the next cycle, and oDbgData @0 = 0.
- Clear vs write collision: in READY, assert iClear together with a write of 32'hA5A5A5A5 to x9. oReady falls. After 32 cycles, x9 = 0 and x2 = SP_INIT.
- Async reset mid-operation: after writing x3=32'h1, assert iRST between clock edges. oReady drops immediately, without an edge. After re-initialisation, x3 = 0.
- Parameter variant: DATA_W=16, ADDR_W=3, NRD=3, BYPASS=0. INIT lasts 8 cycles. A write of 16'hBEEF to x4 with all three ports @4 gives the old value (0) in the write cycle and BEEF on all three ports the next cycle. Port 2 uses bits [47:32].

Source files
------------

// File: rtl/regbank_param.sv
`timescale 1ns/1ps
// regbank_param: parametrised CPU register bank with NRD combinational read
// ports, one write port, optional write-to-read bypass, and an unbypassed
// debug read port. Storage has no reset; a sweep sequencer clears it.
// Latency: reads are combinational; writes land in storage at the next edge.
// Backpressure: oReady=0 during the NREG-cycle init sweep; writes are ignored
// and read ports return 0, so the core must stall on !oReady.
// Ports:
//   iCLK, iRST (async, active-high), iClear (re-run init, wins over writes)
//   iRegWrite/iWriteRegister/iWriteData : single write port
//   iReadRegister/oReadData             : NRD packed read ports, port p at [p*W +: W]
//   iDbgSelect/oDbgData                 : raw storage view for VGA/display taps
//   oReady                              : bank initialised
module regbank_param #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter int          NRD     = 2,
    parameter int          SP_IDX  = 2,
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
    parameter int          BYPASS  = 1
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iClear,
    input  logic                     iRegWrite,
    input  logic [ADDR_W-1:0]        iWriteRegister,
    input  logic [DATA_W-1:0]        iWriteData,
    input  logic [NRD*ADDR_W-1:0]    iReadRegister,
    output logic [NRD*DATA_W-1:0]    oReadData,
    input  logic [ADDR_W-1:0]        iDbgSelect,
    output logic [DATA_W-1:0]        oDbgData,
    output logic                     oReady
);

    localparam int NREG = 1 << ADDR_W;

    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_READY = 1'b1;

    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(NREG - 1);
    localparam logic [ADDR_W:0]   CNT_SP   = (ADDR_W+1)'(SP_IDX);
    localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);

    logic                r_state;
    logic [ADDR_W:0]     r_cnt;
    logic [DATA_W-1:0]   r_mem [NREG];

    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;

    // Control state. Clear restarts the sweep from either state.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (iClear) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
                r_state <= ST_READY;
            end
        end
    end

    // Single storage write port shared by the init sweep and the core.
    // During INIT the sweep owns the port; the entry being cleared when a
    // clear arrives is simply rewritten on the restarted pass.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = iWriteRegister;
        w_wdata = iWriteData;
        if (r_state == ST_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[ADDR_W-1:0];
            w_wdata = (r_cnt == CNT_SP) ? SP_VAL : '0;
        end else if (iRegWrite && !iClear && (iWriteRegister != '0)) begin
            w_we = 1'b1;
        end
    end

    // No reset on storage so it can map onto RAM.
    always_ff @(posedge iCLK) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign oReady   = (r_state == ST_READY);
    assign oDbgData = r_mem[iDbgSelect];

    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;
            logic              w_hit;

            assign w_ra  = iReadRegister[p*ADDR_W +: ADDR_W];
            // Forward only a write that will actually commit this edge.
            assign w_hit = (BYPASS != 0) && iRegWrite && oReady && !iClear
                           && (w_ra == iWriteRegister);

            always_comb begin
                w_rd = r_mem[w_ra];
                if (!oReady || (w_ra == '0)) begin
                    w_rd = '0;
                end else if (w_hit) begin
                    w_rd = iWriteData;
                end
            end

            assign oReadData[p*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

endmodule

// File: tb/tb_regbank_param.sv
`timescale 1ns/1ps
module tb_regbank_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: DATA_W=16, ADDR_W=3, NRD=3, BYPASS=0.
    logic        rst0, rst1;
    logic        clr [2];
    logic        we  [2];
    logic [4:0]  wa  [2];
    logic [31:0] wd  [2];
    logic [4:0]  ra  [2][4];
    logic [4:0]  dsel[2];

    logic [63:0] rd0;
    logic [47:0] rd1;
    logic [31:0] dbg0;
    logic [15:0] dbg1;
    logic        rdy0, rdy1;

    int checks = 0;
    int errors = 0;

    regbank_param u_dut0 (
        .iCLK           (clk),
        .iRST           (rst0),
        .iClear         (clr[0]),
        .iRegWrite      (we[0]),
        .iWriteRegister (wa[0]),
        .iWriteData     (wd[0]),
        .iReadRegister  ({ra[0][1], ra[0][0]}),
        .oReadData      (rd0),
        .iDbgSelect     (dsel[0]),
        .oDbgData       (dbg0),
        .oReady         (rdy0)
    );

    regbank_param #(
        .DATA_W (16),
        .ADDR_W (3),
        .NRD    (3),
        .BYPASS (0)
    ) u_dut1 (
        .iCLK           (clk),
        .iRST           (rst1),
        .iClear         (clr[1]),
        .iRegWrite      (we[1]),
        .iWriteRegister (wa[1][2:0]),
        .iWriteData     (wd[1][15:0]),
        .iReadRegister  ({ra[1][2][2:0], ra[1][1][2:0], ra[1][0][2:0]}),
        .oReadData      (rd1),
        .iDbgSelect     (dsel[1][2:0]),
        .oDbgData       (dbg1),
        .oReady         (rdy1)
    );

    // ---------------- reference model ----------------
    logic [31:0] mmem [2][32];
    bit          mrdy [2];
    int          prog [2];

    function automatic int nreg(int k);   return (k == 0) ? 32 : 8;                 endfunction
    function automatic int nrd(int k);    return (k == 0) ? 2 : 3;                  endfunction
    function automatic bit byp(int k);    return (k == 0);                          endfunction
    function automatic logic [31:0] mask(int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // The model only needs the bank's contents once the sweep has finished,
    // so it fills the whole bank at the moment the NREG-th sweep edge lands.
    task automatic model_step(int k);
        if (!mrdy[k]) begin
            if (clr[k]) begin
                prog[k] <= 0;
            end else begin
                prog[k] <= prog[k] + 1;
                if (prog[k] + 1 == nreg(k)) begin
                    mrdy[k] <= 1'b1;
                    for (int i = 0; i < nreg(k); i++)
                        mmem[k][i] <= (i == 2) ? (32'h0000_3FFC & mask(k)) : 32'h0;
                end
            end
        end else if (clr[k]) begin
            mrdy[k] <= 1'b0;
            prog[k] <= 0;
        end else if (we[k] && wa[k] != 5'd0) begin
            mmem[k][wa[k]] <= wd[k] & mask(k);
        end
    endtask

    always @(posedge clk or posedge rst0) begin
        if (rst0) begin
            mrdy[0] <= 1'b0;
            prog[0] <= 0;
        end else begin
            model_step(0);
        end
    end

    always @(posedge clk or posedge rst1) begin
        if (rst1) begin
            mrdy[1] <= 1'b0;
            prog[1] <= 0;
        end else begin
            model_step(1);
        end
    end

    function automatic logic [31:0] exp_rd(int k, int p);
        logic [4:0] a;
        a = ra[k][p];
        if (!mrdy[k] || a == 5'd0) return 32'h0;
        if (byp(k) && we[k] && !clr[k] && a == wa[k]) return wd[k] & mask(k);
        return mmem[k][a];
    endfunction

    function automatic logic [31:0] get_rd(int k, int p);
        if (k == 0) return rd0[p*32 +: 32];
        return {16'h0, rd1[p*16 +: 16]};
    endfunction

    function automatic logic [31:0] get_dbg(int k);
        return (k == 0) ? dbg0 : {16'h0, dbg1};
    endfunction

    function automatic logic get_rdy(int k);
        return (k == 0) ? rdy0 : rdy1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k), {31'h0, get_rdy(k)}, {31'h0, mrdy[k]});
            for (int p = 0; p < nrd(k); p++)
                chk($sformatf("rd%0d_p%0d", k, p), get_rd(k, p), exp_rd(k, p));
            if (mrdy[k])
                chk($sformatf("dbg%0d", k), get_dbg(k), mmem[k][dsel[k]]);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            clr[k] = 1'b0; we[k] = 1'b0; wa[k] = 5'd0; wd[k] = 32'h0; dsel[k] = 5'd0;
            for (int p = 0; p < 4; p++) ra[k][p] = 5'd0;
        end
    endtask

    // Count edges until the instance reports ready (bounded).
    task automatic wait_ready(int k, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!get_rdy(k) && n < 200);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready0", {31'h0, rdy0}, 32'h0);
        chk("reset_rd0", rd0[31:0], 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Reset sweep: ready rises after exactly NREG edges.
        n0 = 0; n1 = 0;
        for (int e = 1; e <= 200 && !(rdy0 && rdy1); e++) begin
            @(posedge clk);
            #2;
            if (rdy0 && n0 == 0) n0 = e;
            if (rdy1 && n1 == 0) n1 = e;
        end
        chk("init_edges0", n0, 32);
        chk("init_edges1", n1, 8);
        ra[0][0] = 5'd2; ra[0][1] = 5'd5; dsel[0] = 5'd31;
        #1;
        chk("sp_init", rd0[31:0], 32'h0000_3FFC);
        chk("x5_zero", rd0[63:32], 32'h0);
        chk("dbg31_zero", dbg0, 32'h0);

        // Bypass write/read.
        @(posedge clk); #1;
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hDEAD_BEEF; ra[0][1] = 5'd7;
        #1;
        chk("bypass_same_cycle", rd0[63:32], 32'hDEAD_BEEF);
        @(posedge clk); #1;
        we[0] = 1'b0; ra[0][0] = 5'd7; dsel[0] = 5'd7;
        #1;
        chk("x7_p0", rd0[31:0], 32'hDEAD_BEEF);
        chk("x7_p1", rd0[63:32], 32'hDEAD_BEEF);
        chk("x7_dbg", dbg0, 32'hDEAD_BEEF);

        // x0 protection.
        @(posedge clk); #1;
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h1234_5678; ra[0][0] = 5'd0; dsel[0] = 5'd0;
        #1;
        chk("x0_same", rd0[31:0], 32'h0);
        @(posedge clk); #1;
        we[0] = 1'b0;
        #1;
        chk("x0_next", rd0[31:0], 32'h0);
        chk("x0_dbg", dbg0, 32'h0);

        // Clear collides with a write: clear wins.
        @(posedge clk); #1;
        clr[0] = 1'b1; we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        clr[0] = 1'b0; we[0] = 1'b0;
        chk("clear_drops_ready", {31'h0, rdy0}, 32'h0);
        wait_ready(0, n0);
        chk("clear_init_edges", n0, 32);
        ra[0][0] = 5'd9; ra[0][1] = 5'd2;
        #1;
        chk("x9_cleared", rd0[31:0], 32'h0);
        chk("x2_sp_again", rd0[63:32], 32'h0000_3FFC);

        // Async reset between edges.
        @(posedge clk); #1;
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h1; ra[0][0] = 5'd3;
        @(posedge clk); #1;
        we[0] = 1'b0;
        #1;
        chk("x3_written", rd0[31:0], 32'h1);
        rst0 = 1'b1;
        #1;
        chk("async_rst_ready", {31'h0, rdy0}, 32'h0);
        chk("async_rst_rd", rd0[31:0], 32'h0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        wait_ready(0, n0);
        chk("rst_init_edges", n0, 32);
        chk("x3_after_rst", rd0[31:0], 32'h0);

        // Variant: no bypass, three ports.
        @(posedge clk); #1;
        we[1] = 1'b1; wa[1] = 5'd4; wd[1] = 32'h0000_BEEF;
        ra[1][0] = 5'd4; ra[1][1] = 5'd4; ra[1][2] = 5'd4;
        #1;
        chk("v_old_p0", {16'h0, rd1[15:0]}, 32'h0);
        chk("v_old_p2", {16'h0, rd1[47:32]}, 32'h0);
        @(posedge clk); #1;
        we[1] = 1'b0;
        #1;
        chk("v_new_p0", {16'h0, rd1[15:0]}, 32'h0000_BEEF);
        chk("v_new_p1", {16'h0, rd1[31:16]}, 32'h0000_BEEF);
        chk("v_new_p2", {16'h0, rd1[47:32]}, 32'h0000_BEEF);

        // Variant: holding clear pins the sweep; full sweep follows release.
        clr[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        clr[1] = 1'b0;
        chk("v_clear_hold_ready", {31'h0, rdy1}, 32'h0);
        wait_ready(1, n1);
        chk("v_clear_init_edges", n1, 8);

        // Randomised traffic on both instances; the negedge process checks.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                clr[k]  = ($urandom_range(0, 79) == 0);
                we[k]   = $urandom_range(0, 1);
                wa[k]   = 5'($urandom_range(0, nreg(k) - 1));
                wd[k]   = $urandom() & mask(k);
                dsel[k] = 5'($urandom_range(0, nreg(k) - 1));
                for (int p = 0; p < 4; p++)
                    ra[k][p] = ($urandom_range(0, 3) == 0) ? wa[k]
                                                           : 5'($urandom_range(0, nreg(k) - 1));
            end
        end

        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
